// File: rtl/bp_stream_host_ctrl.sv
// Host stream front end: decodes inbound host writes to the NBF loader, MMIO or a control
// register, and merges MMIO outbound words with on-demand status words onto the host stream.
module bp_stream_host_ctrl #(
   parameter int unsigned stream_addr_width_p = 32,
   parameter int unsigned stream_data_width_p = 32,
   parameter logic [31:0] nbf_addr_p          = 32'h10,
   parameter logic [31:0] mmio_addr_p         = 32'h20,
   parameter logic [31:0] ctrl_addr_p         = 32'h30
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic                           prog_done_i,

   input  logic                           stream_v_i,
   input  logic [stream_addr_width_p-1:0] stream_addr_i,
   input  logic [stream_data_width_p-1:0] stream_data_i,
   output logic                           stream_yumi_o,

   output logic                           nbf_v_o,
   output logic [stream_data_width_p-1:0] nbf_data_o,
   input  logic                           nbf_ready_i,

   output logic                           mmio_v_o,
   output logic [stream_data_width_p-1:0] mmio_data_o,
   input  logic                           mmio_ready_i,

   input  logic                           mmio_v_i,
   input  logic [stream_data_width_p-1:0] mmio_data_i,
   output logic                           mmio_yumi_o,

   output logic                           stream_v_o,
   output logic [stream_data_width_p-1:0] stream_data_o,
   input  logic                           stream_ready_i,

   output logic                           run_o
);

   localparam logic [stream_addr_width_p-1:0] NbfAddr  = stream_addr_width_p'(nbf_addr_p);
   localparam logic [stream_addr_width_p-1:0] MmioAddr = stream_addr_width_p'(mmio_addr_p);
   localparam logic [stream_addr_width_p-1:0] CtrlAddr = stream_addr_width_p'(ctrl_addr_p);

   typedef enum logic [0:0] {StLoad = 1'b0, StRun = 1'b1} state_e;

   state_e state_q, state_d;
   logic   in_run;

   logic [7:0] err_cnt_q, err_cnt_d;
   logic [7:0] drop_cnt_q, drop_cnt_d;

   logic                           slot_full_q, slot_full_d;
   logic [stream_data_width_p-1:0] slot_q, slot_d;
   logic [stream_data_width_p-1:0] status_word;

   logic lock_q, lock_d;
   logic gnt_status_q, gnt_status_d;
   logic last_status_q, last_status_d;

   logic hit_nbf, hit_mmio, hit_ctrl, hit_none;
   logic drop_acc, err_acc, ctrl_acc, status_fill;
   logic sel_status, out_v_raw, out_hs, status_hs;

   // ------------------------------------------------------------------
   // Phase FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= StLoad;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad:  if (prog_done_i) state_d = StRun;
         StRun:   state_d = StRun;
         default: state_d = StLoad;
      endcase
   end

   always_comb begin
      in_run = (state_q == StRun);
      run_o  = in_run;
   end

   // ------------------------------------------------------------------
   // Inbound decode and acceptance
   // ------------------------------------------------------------------
   always_comb begin
      hit_nbf  = (stream_addr_i == NbfAddr);
      hit_mmio = (stream_addr_i == MmioAddr);
      hit_ctrl = (stream_addr_i == CtrlAddr);
      hit_none = !(hit_nbf || hit_mmio || hit_ctrl);

      nbf_v_o     = stream_v_i && hit_nbf && !in_run;
      nbf_data_o  = stream_data_i;
      mmio_v_o    = stream_v_i && hit_mmio && in_run;
      mmio_data_o = stream_data_i;

      drop_acc = stream_v_i && hit_nbf && in_run;
      err_acc  = stream_v_i && hit_none;
      // A status request may reuse the slot in the cycle its current word leaves.
      ctrl_acc = stream_v_i && hit_ctrl &&
                 (!stream_data_i[0] || !slot_full_q || status_hs);
      status_fill = ctrl_acc && stream_data_i[0];

      stream_yumi_o = (nbf_v_o && nbf_ready_i) || (mmio_v_o && mmio_ready_i) ||
                      drop_acc || err_acc || ctrl_acc;
   end

   always_comb begin
      err_cnt_d  = err_cnt_q;
      drop_cnt_d = drop_cnt_q;
      if (err_acc && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
      if (drop_acc && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   // ------------------------------------------------------------------
   // Status slot
   // ------------------------------------------------------------------
   always_comb begin
      status_word        = '0;
      status_word[31:0]  = {err_cnt_q, drop_cnt_q, 15'b0, in_run};

      slot_d      = slot_q;
      slot_full_d = slot_full_q;
      if (status_fill) begin
         slot_d      = status_word;
         slot_full_d = 1'b1;
      end else if (status_hs) begin
         slot_full_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Outbound round-robin arbiter with grant lock
   // ------------------------------------------------------------------
   always_comb begin
      if (lock_q) begin
         sel_status = gnt_status_q;
      end else if (mmio_v_i && slot_full_q) begin
         sel_status = !last_status_q;
      end else begin
         sel_status = !mmio_v_i;
      end

      out_v_raw     = sel_status ? slot_full_q : mmio_v_i;
      // Reset must silence the outbound side even if the MMIO source keeps offering.
      stream_v_o    = reset_n_i && out_v_raw;
      stream_data_o = sel_status ? slot_q : mmio_data_i;

      out_hs      = stream_v_o && stream_ready_i;
      mmio_yumi_o = out_hs && !sel_status;
      status_hs   = out_hs && sel_status;

      lock_d        = out_hs ? 1'b0 : (stream_v_o ? 1'b1 : lock_q);
      gnt_status_d  = sel_status;
      last_status_d = out_hs ? sel_status : last_status_q;
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         err_cnt_q     <= 8'h00;
         drop_cnt_q    <= 8'h00;
         slot_full_q   <= 1'b0;
         slot_q        <= '0;
         lock_q        <= 1'b0;
         gnt_status_q  <= 1'b0;
         last_status_q <= 1'b1;
      end else begin
         err_cnt_q     <= err_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
         slot_full_q   <= slot_full_d;
         slot_q        <= slot_d;
         lock_q        <= lock_d;
         gnt_status_q  <= gnt_status_d;
         last_status_q <= last_status_d;
      end
   end

endmodule

// File: doc/bp_stream_host_ctrl.md
BP_STREAM_HOST_CTRL -- requirements
Module: bp_stream_host_ctrl

Interface
REQ-001 SHALL have parameter stream_addr_width_p, default 32, host stream address width.
REQ-002 SHALL have parameter stream_data_width_p, default 32, host stream data width; values below 32 are illegal.
REQ-003 SHALL have parameters nbf_addr_p = 32'h10, mmio_addr_p = 32'h20 and ctrl_addr_p = 32'h30, the decode addresses for the three targets.
REQ-004 SHALL have the ports below (name, direction, width, meaning), clock and reset first:
  clk_i  in  1  single clock; all state is clocked on its rising edge.
  reset_n_i  in  1  reset, asynchronous and active-low.
  prog_done_i  in  1  NBF loader done.
  stream_v_i / stream_addr_i / stream_data_i  in  1/addr/data  inbound host write.
  stream_yumi_o  out  1  inbound write consumed.
  nbf_v_o / nbf_data_o  out  1/data  to NBF loader.
  nbf_ready_i  in  1  NBF loader ready.
  mmio_v_o / mmio_data_o  out  1/data  to MMIO.
  mmio_ready_i  in  1  MMIO ready.
  mmio_v_i / mmio_data_i  in  1/data  MMIO outbound word.
  mmio_yumi_o  out  1  MMIO outbound word consumed.
  stream_v_o / stream_data_o  out  1/data  outbound host word.
  stream_ready_i  in  1  host ready.
  run_o  out  1  controller is in RUN.

Function
REQ-005 SHALL have exactly two phase states, LOAD and RUN; reset enters LOAD; LOAD->RUN occurs on the first clock edge with prog_done_i=1; RUN is left only by reset.
REQ-006 SHALL assert nbf_v_o = stream_v_i & (addr==nbf_addr_p) & LOAD, combinationally, with nbf_data_o = stream_data_i.
REQ-007 SHALL assert mmio_v_o = stream_v_i & (addr==mmio_addr_p) & RUN, with mmio_data_o = stream_data_i; in LOAD, MMIO-addressed writes stall (no yumi) until RUN.
REQ-008 SHALL consume NBF-addressed writes in RUN without forwarding them, incrementing drop_cnt (8-bit, saturating at 8'hFF).
REQ-009 SHALL consume writes to any undecoded address in either phase, incrementing err_cnt (8-bit, saturating at 8'hFF).
REQ-010 SHALL treat a ctrl_addr_p write with data[0]=1 as a status request: load a single-entry status slot with {err_cnt, drop_cnt, 15'b0, RUN}, using the counter values before this cycle's update. The write stalls while the slot is full; a write with data[0]=0 is consumed with no effect.
REQ-011 SHALL assert stream_yumi_o exactly when the decoded target accepts: nbf (v & nbf_ready_i), mmio (v & mmio_ready_i), drop, error, or ctrl (slot empty, or data[0]=0); at most one target per cycle.
REQ-012 SHALL arbitrate stream_v_o between the mmio_v_i source and the status slot round-robin; on a tie, the source not granted last wins; after reset, mmio wins the first tie.
REQ-013 SHALL lock the grant once stream_v_o=1 until the handshake stream_v_o & stream_ready_i completes; stream_v_o and stream_data_o SHALL not change while stalled.
REQ-014 SHALL assert mmio_yumi_o only on a completed handshake while mmio is granted; a status handshake empties the slot in that cycle.
REQ-015 SHALL allow a status slot to be filled (REQ-010) and emptied (REQ-014) in the same cycle; the slot then holds the new word.
REQ-016 SHALL add zero latency on forwarding paths; a status word is visible on stream_v_o no earlier than the cycle after its request.

Reset
REQ-017 SHALL, while reset_n_i=0 and independent of the clock, drive state=LOAD, err_cnt=0, drop_cnt=0, slot empty, grant lock clear, last-grant=status, run_o=0, stream_v_o=0 and mmio_yumi_o=0.
REQ-018 SHALL, on reset assertion during a stalled outbound transfer, drop that word; after reset deassertion the mmio word is re-offered by its source.

Verification
REQ-019 LOAD, write addr 0x10 data 0xDEADBEEF, nbf_ready_i=1 -> nbf_v_o=1, nbf_data_o=0xDEADBEEF, stream_yumi_o=1 in the same cycle.
REQ-020 LOAD, write to 0x20 held 3 cycles, then prog_done_i=1 -> no yumi for those 3 cycles; run_o=1 on the next edge; mmio_v_o=1 and yumi (with mmio_ready_i=1) follow.
REQ-021 RUN, two writes to 0x10, one write to 0x44, then ctrl write data=1 -> all consumed; status word = 0x01020001.
REQ-022 mmio_v_i held high together with a full status slot, stream_ready_i=1 -> outbound order is mmio, status, then mmio (alternating); with stream_ready_i=0 for 4 cycles, data stays stable.
REQ-023 300 undecoded writes, then a status request -> err_cnt field = 0xFF.
REQ-024 reset_n_i pulsed low mid-cycle in RUN with a full slot -> outputs reset immediately; run_o=0, stream_v_o=0.
